// File: rtl/obi_sram_responder.sv
// OBI responder backed by a byte-laned SRAM array: in-order responses after a fixed
// latency, with configurable grant wait states and a cap on outstanding transactions.

module obi_sram_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module obi_sram_responder #(
  parameter int WIDTH           = 32,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int GNT_WAIT        = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [WIDTH/8-1:0] be_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic               rvalid_o,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               err_o
);
  localparam int NUM_LANES     = WIDTH / 8;
  localparam int AW            = $clog2(DEPTH_WORDS);
  localparam int STAGES        = LATENCY - 1;
  localparam logic [3:0]  GW   = 4'(GNT_WAIT);
  localparam logic [3:0]  MO   = 4'(MAX_OUTSTANDING);
  localparam logic [29:0] DW   = 30'(DEPTH_WORDS);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } resp_t;

  logic [3:0]                  wait_cnt, out_cnt;
  logic                        acc, addr_err;
  logic [AW-1:0]               idx;
  logic [NUM_LANES-1:0][7:0]   rd_word;
  logic [STAGES:0]             vld_pipe;
  resp_t                       resp_pipe [STAGES:0];
  resp_t                       resp_in;

  assign gnt_o    = rst_n && req_i && (wait_cnt == GW) && (out_cnt < MO);
  assign acc      = req_i && gnt_o;
  assign addr_err = (|addr_i[1:0]) || (addr_i[31:2] >= DW);
  assign idx      = addr_i[AW+1:2];

  // Errored writes must not alias into the array, hence the addr_err gate.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    obi_sram_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (acc && we_i && !addr_err && be_i[g]),
      .idx   (idx),
      .wdata (wdata_i[g*8 +: 8]),
      .rdata (rd_word[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      out_cnt  <= '0;
    end else begin
      if (acc || !req_i)      wait_cnt <= '0;
      else if (wait_cnt < GW) wait_cnt <= wait_cnt + 4'd1;
      out_cnt <= out_cnt + 4'(acc) - 4'(rvalid_o);
    end
  end

  // Non-valid stages carry zeros so rdata_o/err_o idle at 0 without output gating.
  always_comb begin
    resp_in = '0;
    if (acc) begin
      resp_in.err = addr_err;
      if (!addr_err && !we_i) resp_in.data = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i <= STAGES; i++) resp_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= acc;
      resp_pipe[0] <= resp_in;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        resp_pipe[i] <= resp_pipe[i-1];
      end
    end
  end

  assign rvalid_o = vld_pipe[STAGES];
  assign rdata_o  = resp_pipe[STAGES].data;
  assign err_o    = resp_pipe[STAGES].err;
endmodule

// File: tb/tb_obi_sram_responder.sv
// Three responder configurations share one stimulus stream; a transaction-level
// model tracks each one's grants, memory image and pending responses.

module tb_obi_sram_responder;
  localparam int LAT [3] = '{1, 3, 2};
  localparam int MOS [3] = '{2, 2, 1};
  localparam int GWT [3] = '{0, 0, 3};

  logic clk, rst_n, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [2:0]  gnt, rvalid, err;
  logic [2:0][31:0] rdata;

  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 0;

  obi_sram_responder #(.LATENCY(LAT[0]), .MAX_OUTSTANDING(MOS[0]), .GNT_WAIT(GWT[0])) u_a (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt[0]), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
  obi_sram_responder #(.LATENCY(LAT[1]), .MAX_OUTSTANDING(MOS[1]), .GNT_WAIT(GWT[1])) u_b (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt[1]), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));
  obi_sram_responder #(.LATENCY(LAT[2]), .MAX_OUTSTANDING(MOS[2]), .GNT_WAIT(GWT[2])) u_c (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt[2]), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: memory image with known-byte mask, FIFO of pending responses.
  bit [31:0] mm [3][1024];
  bit [3:0]  mk [3][1024];
  int        pdue [3][16];
  bit        perr [3][16];
  bit [31:0] pdat [3][16];
  bit [31:0] pmsk [3][16];
  int        phd [3], pcnt [3], held [3];

  initial begin : model
    bit eg, ev, ee;
    bit [31:0] ed, em;
    int wi, slot;
    for (int k = 0; k < 3; k++) begin phd[k] = 0; pcnt[k] = 0; held[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        eg = rst_n && req && (held[k] >= GWT[k]) && (pcnt[k] < MOS[k]);
        if (chk_en) begin
          checks++;
          if (gnt[k] !== eg) begin
            errors++;
            $display("FAIL gnt dut%0d cyc %0d: got %b expected %b", k, cyc, gnt[k], eg);
          end
        end
        ev = 0; ee = 0; ed = 0; em = '1;
        if (pcnt[k] > 0 && pdue[k][phd[k]] == cyc) begin
          ev = 1; ee = perr[k][phd[k]]; ed = pdat[k][phd[k]]; em = pmsk[k][phd[k]];
          phd[k] = (phd[k] + 1) % 16; pcnt[k]--;
        end
        if (chk_en) begin
          checks++;
          if (rvalid[k] !== ev || err[k] !== ee || (rdata[k] & em) !== (ed & em)) begin
            errors++;
            $display("FAIL resp dut%0d cyc %0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h mask=%h",
                     k, cyc, rvalid[k], err[k], rdata[k], ev, ee, ed, em);
          end
        end
        if (eg) begin
          slot = (phd[k] + pcnt[k]) % 16;
          pdue[k][slot] = cyc + LAT[k];
          perr[k][slot] = 0; pdat[k][slot] = 0; pmsk[k][slot] = '1;
          wi = int'(addr >> 2);
          if (addr[1:0] != 2'b00 || (addr >> 2) >= 32'd1024) perr[k][slot] = 1;
          else if (we) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) begin mm[k][wi][8*b +: 8] = wdata[8*b +: 8]; mk[k][wi][b] = 1; end
          end else begin
            pdat[k][slot] = mm[k][wi];
            for (int b = 0; b < 4; b++) pmsk[k][slot][8*b +: 8] = {8{mk[k][wi][b]}};
          end
          pcnt[k]++;
        end
        if (!req || eg) held[k] = 0; else held[k]++;
        if (!rst_n) begin phd[k] = 0; pcnt[k] = 0; held[k] = 0; end
      end
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
    req = r; we = w; addr = a; be = b; wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 0; drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    chk_en = 1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({gnt[k], rvalid[k], err[k], rdata[k]} !== 35'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got g=%b v=%b e=%b d=%h expected all 0",
                 k, gnt[k], rvalid[k], err[k], rdata[k]);
      end
    end
    checks++;
    if (u_a.out_cnt !== 4'd0 || u_b.out_cnt !== 4'd0 || u_c.out_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_out_cnt: got %0d/%0d/%0d expected 0", u_a.out_cnt, u_b.out_cnt, u_c.out_cnt);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_read();
    drive(1, 1, 32'h10, 4'hF, 32'hDEADBEEF); tick();
    checks++;
    if (rvalid[0] !== 1 || err[0] !== 0 || rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL wr_resp: got v=%b e=%b d=%h expected 1 0 00000000", rvalid[0], err[0], rdata[0]);
    end
    drive(1, 0, 32'h10, 4'h0, 32'h0); tick();
    checks++;
    if (rvalid[0] !== 1 || err[0] !== 0 || rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_resp: got v=%b e=%b d=%h expected 1 0 deadbeef", rvalid[0], err[0], rdata[0]);
    end
    drive(0, 0, 0, 0, 0); tick();
    checks++;
    if (rvalid[0] !== 0 || rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL rd_idle: got v=%b d=%h expected 0 00000000", rvalid[0], rdata[0]);
    end
    repeat (6) tick();
  endtask

  task automatic test_byte_en();
    drive(1, 1, 32'h20, 4'hF, 32'h11223344); tick();
    drive(1, 1, 32'h20, 4'b0101, 32'hAABBCCDD); tick();
    drive(1, 0, 32'h20, 4'h0, 32'h0); tick();
    checks++;
    if (rvalid[0] !== 1 || rdata[0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_en: got v=%b d=%h expected 1 11bb33dd", rvalid[0], rdata[0]);
    end
    drive(0, 0, 0, 0, 0); repeat (6) tick();
  endtask

  task automatic test_errors();
    logic [31:0] ea [4] = '{32'h13, 32'h1000, 32'h1010, 32'h11};
    bit          ew [4] = '{0, 0, 1, 1};
    for (int j = 0; j < 4; j++) begin
      drive(1, ew[j], ea[j], 4'hF, 32'h0BADF00D); tick();
      checks++;
      if (rvalid[0] !== 1 || err[0] !== 1 || rdata[0] !== 32'h0) begin
        errors++;
        $display("FAIL err_resp addr %h: got v=%b e=%b d=%h expected 1 1 00000000",
                 ea[j], rvalid[0], err[0], rdata[0]);
      end
    end
    drive(1, 0, 32'h10, 4'h0, 32'h0); tick();
    checks++;
    if (rvalid[0] !== 1 || err[0] !== 0 || rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL err_untouched: got e=%b d=%h expected 0 deadbeef", err[0], rdata[0]);
    end
    drive(0, 0, 0, 0, 0); repeat (6) tick();
  endtask

  // Target u_b: LATENCY=3, MAX_OUTSTANDING=2, so grants stall after two accepts.
  task automatic test_backpressure();
    logic [31:0] pat [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    int exp_g [4] = '{0, 1, 4, 5};
    int gc [8], rc [8];
    logic [31:0] rd [8];
    logic re [8];
    int i, ng, nr;
    bit g, over;
    for (int j = 0; j < 4; j++) begin
      drive(1, 1, 32'h40 + 32'(4*j), 4'hF, pat[j]);
      g = 0;
      for (int c = 0; c < 20 && !g; c++) begin
        @(negedge clk); g = gnt[1];
        tick();
      end
    end
    drive(0, 0, 0, 0, 0); repeat (6) tick();
    i = 0; ng = 0; nr = 0; over = 0;
    drive(1, 0, 32'h40, 4'h0, 32'h0);
    for (int c = 0; c < 30 && nr < 4; c++) begin
      @(negedge clk);
      g = gnt[1];
      if (g && ng < 8) begin gc[ng] = c; ng++; end
      if (rvalid[1] && nr < 8) begin rc[nr] = c; rd[nr] = rdata[1]; re[nr] = err[1]; nr++; end
      if (u_b.out_cnt > 4'd2) over = 1;
      tick();
      if (g) begin
        i++;
        if (i < 4) addr = 32'h40 + 32'(4*i); else req = 0;
      end
    end
    checks++;
    if (ng != 4 || nr != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d grants %0d responses expected 4 4", ng, nr);
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (gc[j] != exp_g[j] || rc[j] != gc[j] + 3 || rd[j] !== pat[j] || re[j] !== 0) begin
          errors++;
          $display("FAIL bp_txn%0d: got gnt@%0d rsp@%0d d=%h e=%b expected gnt@%0d rsp@%0d d=%h e=0",
                   j, gc[j], rc[j], rd[j], re[j], exp_g[j], exp_g[j] + 3, pat[j]);
        end
      end
    end
    checks++;
    if (over) begin
      errors++;
      $display("FAIL bp_out_cnt: got above 2 expected at most 2");
    end
    repeat (6) tick();
  endtask

  // Target u_c: GNT_WAIT=3, LATENCY=2; reset lands while its one response is in flight.
  task automatic test_wait_reset();
    int first;
    bit seen;
    first = -1;
    drive(1, 0, 32'h40, 4'h0, 32'h0);
    for (int c = 0; c < 12 && first < 0; c++) begin
      @(negedge clk);
      if (gnt[2]) first = c;
      tick();
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL gnt_wait: got first grant cycle %0d expected 3", first);
    end
    checks++;
    if (u_c.out_cnt !== 4'd1) begin
      errors++;
      $display("FAIL pending_before_reset: got out_cnt %0d expected 1", u_c.out_cnt);
    end
    drive(0, 0, 0, 0, 0); rst_n = 0; tick();
    rst_n = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rvalid[2]) seen = 1;
      tick();
    end
    checks++;
    if (seen || u_c.out_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_flush: got rvalid_seen=%b out_cnt=%0d expected 0 0", seen, u_c.out_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'h40 + 32'(4 * $urandom_range(0, 15));
      else if (sel == 7) a = 32'h40 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h1000 + 32'(4 * $urandom_range(0, 255));
      else               a = 32'hFFFFFFFC;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
            4'($urandom_range(0, 15)), $urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1; drive(0, 0, 0, 0, 0);
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 0; drive(0, 0, 0, 0, 0);
    test_reset();
    test_write_read();
    test_byte_en();
    test_errors();
    test_backpressure();
    test_wait_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
